// File: rtl/saturn_bus_pkg.sv
// Shared definitions for the Saturn bus RAM card: command codes,
// bus address width, responder state encoding and the ID nibble helper.
package saturn_bus_pkg;

  localparam int BUS_ADDR_W = 20;

  localparam logic [3:0] CMD_NOP         = 4'h0;
  localparam logic [3:0] CMD_ID          = 4'h1;
  localparam logic [3:0] CMD_PC_READ     = 4'h2;
  localparam logic [3:0] CMD_DP_READ     = 4'h3;
  localparam logic [3:0] CMD_PC_WRITE    = 4'h4;
  localparam logic [3:0] CMD_DP_WRITE    = 4'h5;
  localparam logic [3:0] CMD_LOAD_PC     = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP     = 4'h7;
  localparam logic [3:0] CMD_CONFIGURE   = 4'h8;
  localparam logic [3:0] CMD_UNCONFIGURE = 4'h9;
  localparam logic [3:0] CMD_BUS_RESET   = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_ID    = 3'd4
  } state_t;

  // Destination of a completed 5-nibble address transfer
  typedef enum logic [1:0] {
    TGT_PC   = 2'd0,
    TGT_DP   = 2'd1,
    TGT_BASE = 2'd2
  } tgt_t;

  // Nibble idx of the device identifier, least-significant first; 0 past the end
  function automatic logic [3:0] id_nibble(input logic [19:0] id, input logic [2:0] idx);
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = id[3:0];
      3'd1:    nib = id[7:4];
      3'd2:    nib = id[11:8];
      3'd3:    nib = id[15:12];
      3'd4:    nib = id[19:16];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/saturn_nibble_ram.sv
// Single-port nibble-wide RAM with synchronous write and registered read.
// Contents are deliberately not reset.
module saturn_nibble_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [3:0]           i_wdata,
  output logic [3:0]           o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [3:0] mem_r [0:DEPTH-1];
  logic [3:0] rdata_r;

  // Write port and registered read of the addressed location
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_addr] <= i_wdata;
    end
    rdata_r <= mem_r[i_addr];
  end

  assign o_rdata = rdata_r;

endmodule

// File: rtl/saturn_bus_ram_card.sv
// Saturn bus RAM card responder: decodes controller commands, keeps its own
// PC/DP pointers and a configured base, and serves reads/writes in its window.
module saturn_bus_ram_card
  import saturn_bus_pkg::*;
#(
  parameter int          ADDR_BITS = 10,
  parameter logic [19:0] DEV_ID    = 20'h0F0F5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic       i_phase_0,
  input  logic       i_bus_clk_en,
  input  logic       i_bus_is_data,
  input  logic [3:0] i_bus_nibble_in,
  output logic [3:0] o_bus_nibble_out,
  input  logic       i_bus_daisy,
  output logic       o_bus_daisy,
  output logic       o_bus_active
);

  localparam int HI_W = BUS_ADDR_W - ADDR_BITS;
  localparam logic [BUS_ADDR_W-1:0] LOW_MASK = (20'd1 << ADDR_BITS) - 20'd1;

  state_t                state_r, state_s;
  tgt_t                  tgt_r, tgt_s;
  logic [BUS_ADDR_W-1:0] pc_r, pc_s;
  logic [BUS_ADDR_W-1:0] dp_r, dp_s;
  logic [BUS_ADDR_W-1:0] shift_r, shift_s;
  logic [HI_W-1:0]       base_hi_r, base_hi_s;
  logic                  configured_r, configured_s;
  logic                  sel_dp_r, sel_dp_s;
  logic [2:0]            cnt_r, cnt_s;
  logic [3:0]            nibble_out_r, nibble_out_s;

  logic                  strobe_s;
  logic [BUS_ADDR_W-1:0] ptr_s;
  logic [BUS_ADDR_W-1:0] addr_word_s;
  logic [BUS_ADDR_W-1:0] base_word_s;
  logic                  in_window_s;
  logic                  pc_in_window_s;
  logic                  id_respond_s;
  logic                  ram_we_s;
  logic [3:0]            ram_rdata_s;

  assign strobe_s       = i_clk_en && i_bus_clk_en && i_phase_0;
  assign addr_word_s    = {i_bus_nibble_in, shift_r[BUS_ADDR_W-1:4]};
  assign base_word_s    = addr_word_s & ~LOW_MASK;
  assign in_window_s    = configured_r && (ptr_s[BUS_ADDR_W-1:ADDR_BITS] == base_hi_r);
  assign pc_in_window_s = configured_r && (pc_r[BUS_ADDR_W-1:ADDR_BITS] == base_hi_r);
  assign id_respond_s   = !configured_r && i_bus_daisy;

  // Pointer currently selected by the last read/write command
  always_comb begin
    ptr_s = pc_r;
    if (sel_dp_r) begin
      ptr_s = dp_r;
    end else begin
      ptr_s = pc_r;
    end
  end

  saturn_nibble_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we_s),
    .i_addr  (ptr_s[ADDR_BITS-1:0]),
    .i_wdata (i_bus_nibble_in),
    .o_rdata (ram_rdata_s)
  );

  // Command decode and data-strobe handling; all changes gated by the bus strobe
  always_comb begin
    state_s      = state_r;
    tgt_s        = tgt_r;
    pc_s         = pc_r;
    dp_s         = dp_r;
    shift_s      = shift_r;
    base_hi_s    = base_hi_r;
    configured_s = configured_r;
    sel_dp_s     = sel_dp_r;
    cnt_s        = cnt_r;
    ram_we_s     = 1'b0;

    if (strobe_s && !i_bus_is_data) begin
      // A command always aborts whatever was in progress
      cnt_s = 3'd0;
      case (i_bus_nibble_in)
        CMD_LOAD_PC: begin
          state_s = S_ADDR;
          tgt_s   = TGT_PC;
        end
        CMD_LOAD_DP: begin
          state_s = S_ADDR;
          tgt_s   = TGT_DP;
        end
        CMD_CONFIGURE: begin
          state_s = S_ADDR;
          tgt_s   = TGT_BASE;
        end
        CMD_PC_READ: begin
          state_s  = S_READ;
          sel_dp_s = 1'b0;
        end
        CMD_DP_READ: begin
          state_s  = S_READ;
          sel_dp_s = 1'b1;
        end
        CMD_PC_WRITE: begin
          state_s  = S_WRITE;
          sel_dp_s = 1'b0;
        end
        CMD_DP_WRITE: begin
          state_s  = S_WRITE;
          sel_dp_s = 1'b1;
        end
        CMD_ID: begin
          state_s = S_ID;
        end
        CMD_UNCONFIGURE: begin
          state_s = S_IDLE;
          if (pc_in_window_s) begin
            configured_s = 1'b0;
          end else begin
            configured_s = configured_r;
          end
        end
        CMD_BUS_RESET: begin
          state_s      = S_IDLE;
          configured_s = 1'b0;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else if (strobe_s) begin
      case (state_r)
        S_ADDR: begin
          shift_s = addr_word_s;
          if (cnt_r == 3'd4) begin
            state_s = S_IDLE;
            cnt_s   = 3'd0;
            case (tgt_r)
              TGT_PC: pc_s = addr_word_s;
              TGT_DP: dp_s = addr_word_s;
              TGT_BASE: begin
                // Only the first configure down an unconfigured daisy chain lands
                if (!configured_r && i_bus_daisy) begin
                  base_hi_s    = base_word_s[BUS_ADDR_W-1:ADDR_BITS];
                  configured_s = 1'b1;
                end else begin
                  base_hi_s = base_hi_r;
                end
              end
              default: begin
                pc_s = pc_r;
              end
            endcase
          end else begin
            cnt_s = cnt_r + 3'd1;
          end
        end
        S_READ, S_WRITE: begin
          // Writes outside the window are dropped but the pointer still advances
          ram_we_s = (state_r == S_WRITE) && in_window_s;
          if (sel_dp_r) begin
            dp_s = dp_r + 20'd1;
          end else begin
            pc_s = pc_r + 20'd1;
          end
        end
        S_ID: begin
          if (cnt_r < 3'd5) begin
            cnt_s = cnt_r + 3'd1;
          end else begin
            cnt_s = cnt_r;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Read-data prefetch source: memory in read state, identifier in ID state
  always_comb begin
    nibble_out_s = 4'h0;
    if (state_r == S_READ) begin
      nibble_out_s = ram_rdata_s;
    end else if ((state_r == S_ID) && id_respond_s && (cnt_r < 3'd5)) begin
      nibble_out_s = id_nibble(DEV_ID, cnt_r);
    end else begin
      nibble_out_s = 4'h0;
    end
  end

  // Responder state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= S_IDLE;
      tgt_r        <= TGT_PC;
      pc_r         <= 20'h00000;
      dp_r         <= 20'h00000;
      shift_r      <= 20'h00000;
      base_hi_r    <= '0;
      configured_r <= 1'b0;
      sel_dp_r     <= 1'b0;
      cnt_r        <= 3'd0;
      nibble_out_r <= 4'h0;
    end else begin
      state_r      <= state_s;
      tgt_r        <= tgt_s;
      pc_r         <= pc_s;
      dp_r         <= dp_s;
      shift_r      <= shift_s;
      base_hi_r    <= base_hi_s;
      configured_r <= configured_s;
      sel_dp_r     <= sel_dp_s;
      cnt_r        <= cnt_s;
      nibble_out_r <= nibble_out_s;
    end
  end

  assign o_bus_nibble_out = nibble_out_r;
  assign o_bus_daisy      = configured_r && i_bus_daisy;
  assign o_bus_active     = ((state_r == S_READ) && in_window_s) ||
                            ((state_r == S_ID) && id_respond_s && (cnt_r < 3'd5));

endmodule

// File: tb/tb_saturn_bus_ram_card.sv
// Directed bench for saturn_bus_ram_card: a vector table of bus strobes with
// expected outputs, followed by hand-written daisy, clock-enable and reset cases.
module tb_saturn_bus_ram_card;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_clk_en;
  logic       i_phase_0;
  logic       i_bus_clk_en;
  logic       i_bus_is_data;
  logic [3:0] i_bus_nibble_in;
  logic [3:0] o_bus_nibble_out;
  logic       i_bus_daisy;
  logic       o_bus_daisy;
  logic       o_bus_active;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       is_data;
    logic [3:0] nib;
    logic       chk_out;
    logic [3:0] exp_out;
    logic       exp_act;
    logic       exp_daisy;
  } vec_t;

  vec_t vecs[$];

  saturn_bus_ram_card dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_clk_en         (i_clk_en),
    .i_phase_0        (i_phase_0),
    .i_bus_clk_en     (i_bus_clk_en),
    .i_bus_is_data    (i_bus_is_data),
    .i_bus_nibble_in  (i_bus_nibble_in),
    .o_bus_nibble_out (o_bus_nibble_out),
    .i_bus_daisy      (i_bus_daisy),
    .o_bus_daisy      (o_bus_daisy),
    .o_bus_active     (o_bus_active)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus strobe, then let the prefetch settle before anything is sampled
  task automatic strobe(input logic is_data, input logic [3:0] nib);
    @(negedge i_clk);
    i_bus_is_data   = is_data;
    i_bus_nibble_in = nib;
    i_bus_clk_en    = 1'b1;
    i_phase_0       = 1'b1;
    @(negedge i_clk);
    i_bus_clk_en = 1'b0;
    i_phase_0    = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic add(input logic d, input logic [3:0] n, input logic co,
                     input logic [3:0] eo, input logic ea, input logic ed);
    vec_t v;
    v.is_data = d; v.nib = n; v.chk_out = co;
    v.exp_out = eo; v.exp_act = ea; v.exp_daisy = ed;
    vecs.push_back(v);
  endtask

  // Command followed by five address nibbles (LSN first), no output checks
  task automatic add_addr(input logic [3:0] cmd, input logic [19:0] a, input logic ed_end);
    logic [19:0] w;
    w = a;
    add(1'b0, cmd, 1'b0, 4'h0, 1'b0, (cmd == 4'h8) ? 1'b0 : ed_end);
    for (int k = 0; k < 5; k++) begin
      add(1'b1, w[3:0], 1'b0, 4'h0, 1'b0, (cmd == 4'h8 && k < 4) ? 1'b0 : ed_end);
      w = w >> 4;
    end
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1; i_clk_en = 1'b1; i_phase_0 = 1'b0; i_bus_clk_en = 1'b0;
    i_bus_is_data = 1'b0; i_bus_nibble_in = 4'h0; i_bus_daisy = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("reset_out",   o_bus_nibble_out, 4'h0);
    chk("reset_act",   {3'b000, o_bus_active}, 4'h0);
    chk("reset_daisy", {3'b000, o_bus_daisy}, 4'h0);

    // ID readout 5,F,0,F,0 then silent
    add(1'b0, 4'h1, 1'b1, 4'h5, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0);
    // Configure at 04000, second configure at 08000 ignored
    add_addr(4'h8, 20'h04000, 1'b1);
    add(1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) add(1'b1, (k == 3) ? 4'h8 : 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 1'b1);
    // Write A,B,C at 04010 through DP, read back through PC
    add_addr(4'h7, 20'h04010, 1'b1);
    add(1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'hB, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 1'b1);
    add_addr(4'h6, 20'h04010, 1'b1);
    add(1'b0, 4'h2, 1'b1, 4'hA, 1'b1, 1'b1);
    add(1'b1, 4'h0, 1'b1, 4'hB, 1'b1, 1'b1);
    add(1'b1, 4'h0, 1'b1, 4'hC, 1'b1, 1'b1);
    add(1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    // Top of window, then just past it
    add_addr(4'h6, 20'h043FF, 1'b1);
    add(1'b0, 4'h2, 1'b0, 4'h0, 1'b1, 1'b1);
    add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    // 7 at 04000, then an out-of-window write of 3 at 04400 must not alias
    add_addr(4'h7, 20'h04000, 1'b1);
    add(1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b1);
    add_addr(4'h7, 20'h04400, 1'b1);
    add(1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1);
    add_addr(4'h6, 20'h04000, 1'b1);
    add(1'b0, 4'h2, 1'b1, 4'h7, 1'b1, 1'b1);
    // PC wraps FFFFF -> 00000; UNCONFIGURE with PC outside window keeps config
    add_addr(4'h6, 20'hFFFFF, 1'b1);
    add(1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h9, 1'b0, 4'h0, 1'b0, 1'b1);
    // Partial LOAD_PC aborted by a command keeps the old PC (04011 holds B)
    add_addr(4'h6, 20'h04011, 1'b1);
    add(1'b0, 4'h6, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h2, 1'b1, 4'hB, 1'b1, 1'b1);
    // UNCONFIGURE with PC in window, reconfigure, BUS_RESET
    add(1'b0, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0);
    add(1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0);
    add_addr(4'h8, 20'h04000, 1'b1);
    add(1'b0, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      strobe(vecs[i].is_data, vecs[i].nib);
      if (vecs[i].chk_out) chk($sformatf("vec%0d_out", i), o_bus_nibble_out, vecs[i].exp_out);
      chk($sformatf("vec%0d_act", i),   {3'b000, o_bus_active}, {3'b000, vecs[i].exp_act});
      chk($sformatf("vec%0d_daisy", i), {3'b000, o_bus_daisy},  {3'b000, vecs[i].exp_daisy});
    end

    // Configure is refused while upstream is unconfigured
    i_bus_daisy = 1'b0;
    strobe(1'b0, 4'h8);
    for (int k = 0; k < 5; k++) strobe(1'b1, (k == 3) ? 4'h4 : 4'h0);
    chk("cfg_blocked_daisy", {3'b000, o_bus_daisy}, 4'h0);
    strobe(1'b0, 4'h1);
    chk("id_blocked_act", {3'b000, o_bus_active}, 4'h0);
    i_bus_daisy = 1'b1;
    @(negedge i_clk);
    chk("cfg_blocked_after", {3'b000, o_bus_daisy}, 4'h0);
    chk("id_daisy_act", {3'b000, o_bus_active}, 4'h1);

    // Strobe with clock enable low must not decode the NOP
    i_clk_en = 1'b0;
    strobe(1'b0, 4'h0);
    chk("clk_en_gate_act", {3'b000, o_bus_active}, 4'h1);
    i_clk_en = 1'b1;

    // Reconfigure, read, start a DP_WRITE and reset in the middle of it
    strobe(1'b0, 4'h8);
    for (int k = 0; k < 5; k++) strobe(1'b1, (k == 3) ? 4'h4 : 4'h0);
    chk("recfg_daisy", {3'b000, o_bus_daisy}, 4'h1);
    strobe(1'b0, 4'h6);
    for (int k = 0; k < 5; k++) strobe(1'b1, (k == 1) ? 4'h1 : ((k == 3) ? 4'h4 : 4'h0));
    strobe(1'b0, 4'h2);
    chk("pre_rst_out", o_bus_nibble_out, 4'hA);
    strobe(1'b0, 4'h5);
    strobe(1'b1, 4'h9);
    pulse_reset();
    chk("rst_out",   o_bus_nibble_out, 4'h0);
    chk("rst_act",   {3'b000, o_bus_active}, 4'h0);
    chk("rst_daisy", {3'b000, o_bus_daisy}, 4'h0);
    strobe(1'b0, 4'h2);
    chk("rst_read_act", {3'b000, o_bus_active}, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
